decode_stage: RTL and testbench

Decode stage of the pipelined ARM core. It takes the instruction and PC+8 produced by the fetch stage and decodes the control word. It reads the register file and extends the immediate. All operands and controls are registered into the decode/execute pipeline register. The register file lives here, and the writeback stage writes it through the W port.

---
 rtl/arm_pkg.sv | 54 +++++
 rtl/regfile.sv | 52 +++++
 rtl/decode_stage.sv | 168 ++++++++++++++++
 tb/tb_decode_stage.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_pkg.sv
// Shared encodings and control types for the ARM decode stage.
// Imported by the decoder/pipeline register and the register file.
package arm_pkg;

    localparam logic [1:0] OpDp  = 2'b00;
    localparam logic [1:0] OpMem = 2'b01;
    localparam logic [1:0] OpBr  = 2'b10;

    localparam logic [3:0] CmdAdd = 4'b0100;
    localparam logic [3:0] CmdSub = 4'b0010;
    localparam logic [3:0] CmdAnd = 4'b0000;
    localparam logic [3:0] CmdOrr = 4'b1100;
    localparam logic [3:0] CmdCmp = 4'b1010;

    localparam logic [3:0] RegPc = 4'd15;
    localparam logic [3:0] RegLr = 4'd14;

    typedef enum logic [1:0] {
        AluAdd = 2'b00,
        AluSub = 2'b01,
        AluAnd = 2'b10,
        AluOrr = 2'b11
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        ImmDp  = 2'b00,
        ImmMem = 2'b01,
        ImmBr  = 2'b10
    } imm_src_e;

    typedef struct packed {
        logic      reg_write;
        logic      mem_write;
        logic      mem_to_reg;
        logic      alu_src;
        logic      branch;
        logic      pc_src;
        alu_ctrl_e alu_control;
        logic [1:0] flag_write;
        logic      illegal;
    } ctrl_t;

    function automatic logic [31:0] extend_imm(input logic [23:0] imm, input imm_src_e src);
        logic [31:0] w_ext;
        case (src)
            ImmDp:   w_ext = {24'd0, imm[7:0]};
            ImmMem:  w_ext = {20'd0, imm[11:0]};
            ImmBr:   w_ext = {{6{imm[23]}}, imm, 2'b00};
            default: w_ext = '0;
        endcase
        return w_ext;
    endfunction

endpackage

// File: rtl/regfile.sv
// 15 x 32 register file: two combinational read ports with R15 = PC+8 and
// same-cycle write-through, one write port, synchronous clear.
module regfile
    import arm_pkg::*;
#(
    parameter int unsigned NREGS = 15
) (
    input  logic        clock,
    input  logic        rst,
    input  logic [3:0]  i_ra1,
    input  logic [3:0]  i_ra2,
    input  logic        i_we3,
    input  logic [3:0]  i_wa3,
    input  logic [31:0] i_wd3,
    input  logic [31:0] i_pc_plus8,
    output logic [31:0] o_rd1,
    output logic [31:0] o_rd2
);

    logic [31:0] r_regs [NREGS];

    always_ff @(posedge clock) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we3 && (i_wa3 != RegPc)) begin
            r_regs[i_wa3] <= i_wd3;
        end
    end

    // Bypass lets writeback and decode share a cycle without a hazard stall.
    always_comb begin
        o_rd1 = '0;
        o_rd2 = '0;
        if (i_ra1 == RegPc) begin
            o_rd1 = i_pc_plus8;
        end else if (i_we3 && (i_wa3 == i_ra1)) begin
            o_rd1 = i_wd3;
        end else begin
            o_rd1 = r_regs[i_ra1];
        end
        if (i_ra2 == RegPc) begin
            o_rd2 = i_pc_plus8;
        end else if (i_we3 && (i_wa3 == i_ra2)) begin
            o_rd2 = i_wd3;
        end else begin
            o_rd2 = r_regs[i_ra2];
        end
    end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: control decode, register read, immediate extend and the
// decode/execute pipeline register.
module decode_stage
    import arm_pkg::*;
#(
    parameter int unsigned NREGS = 15
) (
    input  logic        clock,
    input  logic        rst,
    input  logic [31:0] instD,
    input  logic [31:0] pcPlus8D,
    input  logic        enE,
    input  logic        flushE,
    input  logic        regWriteW,
    input  logic [3:0]  wa3W,
    input  logic [31:0] wd3W,
    output logic [31:0] rd1E,
    output logic [31:0] rd2E,
    output logic [31:0] extImmE,
    output logic [3:0]  wa3E,
    output logic [3:0]  ra1E,
    output logic [3:0]  ra2E,
    output logic        regWriteE,
    output logic        memWriteE,
    output logic        memtoRegE,
    output logic        aluSrcE,
    output logic        branchE,
    output logic        pcSrcE,
    output logic [1:0]  aluControlE,
    output logic [1:0]  flagWriteE,
    output logic [3:0]  condE,
    output logic        illegalE
);

    logic [1:0]  w_op;
    logic [5:0]  w_funct;
    logic [3:0]  w_cmd;
    logic [3:0]  w_rn;
    logic [3:0]  w_rd;
    logic [3:0]  w_ra1;
    logic [3:0]  w_ra2;
    logic [3:0]  w_wa3;
    logic [31:0] w_rd1;
    logic [31:0] w_rd2;
    logic [31:0] w_ext_imm;
    imm_src_e    w_imm_src;
    ctrl_t       w_ctrl;

    ctrl_t       r_ctrl;
    logic [31:0] r_rd1;
    logic [31:0] r_rd2;
    logic [31:0] r_ext_imm;
    logic [3:0]  r_wa3;
    logic [3:0]  r_ra1;
    logic [3:0]  r_ra2;
    logic [3:0]  r_cond;

    assign w_op    = instD[27:26];
    assign w_funct = instD[25:20];
    assign w_cmd   = w_funct[4:1];
    assign w_rn    = instD[19:16];
    assign w_rd    = instD[15:12];

    always_comb begin
        w_ctrl    = '0;
        w_imm_src = ImmDp;
        w_ra1     = w_rn;
        w_ra2     = instD[3:0];
        w_wa3     = w_rd;
        case (w_op)
            OpDp: begin
                w_ctrl.alu_src = w_funct[5];
                case (w_cmd)
                    CmdAdd: begin w_ctrl.alu_control = AluAdd; w_ctrl.reg_write = 1'b1; end
                    CmdSub: begin w_ctrl.alu_control = AluSub; w_ctrl.reg_write = 1'b1; end
                    CmdAnd: begin w_ctrl.alu_control = AluAnd; w_ctrl.reg_write = 1'b1; end
                    CmdOrr: begin w_ctrl.alu_control = AluOrr; w_ctrl.reg_write = 1'b1; end
                    CmdCmp: w_ctrl.alu_control = AluSub;
                    default: w_ctrl.illegal = 1'b1;
                endcase
                // Logical ops leave C/V alone; only arithmetic updates them.
                if (!w_ctrl.illegal) begin
                    w_ctrl.flag_write = {w_funct[0], w_funct[0] &&
                        (w_cmd == CmdAdd || w_cmd == CmdSub || w_cmd == CmdCmp)};
                end
            end
            OpMem: begin
                w_ctrl.alu_src     = 1'b1;
                w_imm_src          = ImmMem;
                w_ctrl.alu_control = w_funct[3] ? AluAdd : AluSub;
                if (w_funct[0]) begin
                    w_ctrl.reg_write  = 1'b1;
                    w_ctrl.mem_to_reg = 1'b1;
                end else begin
                    w_ctrl.mem_write = 1'b1;
                    w_ra2            = w_rd;
                end
            end
            OpBr: begin
                w_ctrl.branch    = 1'b1;
                w_ctrl.alu_src   = 1'b1;
                w_ctrl.reg_write = w_funct[4];
                w_imm_src        = ImmBr;
                w_ra1            = RegPc;
                w_wa3            = RegLr;
            end
            default: w_ctrl.illegal = 1'b1;
        endcase
        w_ctrl.pc_src = ((w_wa3 == RegPc) && w_ctrl.reg_write) || w_ctrl.branch;
    end

    assign w_ext_imm = extend_imm(instD[23:0], w_imm_src);

    regfile #(
        .NREGS(NREGS)
    ) u_regfile (
        .clock      (clock),
        .rst        (rst),
        .i_ra1      (w_ra1),
        .i_ra2      (w_ra2),
        .i_we3      (regWriteW),
        .i_wa3      (wa3W),
        .i_wd3      (wd3W),
        .i_pc_plus8 (pcPlus8D),
        .o_rd1      (w_rd1),
        .o_rd2      (w_rd2)
    );

    always_ff @(posedge clock) begin
        if (rst || flushE) begin
            r_ctrl    <= '0;
            r_rd1     <= '0;
            r_rd2     <= '0;
            r_ext_imm <= '0;
            r_wa3     <= '0;
            r_ra1     <= '0;
            r_ra2     <= '0;
            r_cond    <= '0;
        end else if (enE) begin
            r_ctrl    <= w_ctrl;
            r_rd1     <= w_rd1;
            r_rd2     <= w_rd2;
            r_ext_imm <= w_ext_imm;
            r_wa3     <= w_wa3;
            r_ra1     <= w_ra1;
            r_ra2     <= w_ra2;
            r_cond    <= instD[31:28];
        end
    end

    assign rd1E        = r_rd1;
    assign rd2E        = r_rd2;
    assign extImmE     = r_ext_imm;
    assign wa3E        = r_wa3;
    assign ra1E        = r_ra1;
    assign ra2E        = r_ra2;
    assign condE       = r_cond;
    assign regWriteE   = r_ctrl.reg_write;
    assign memWriteE   = r_ctrl.mem_write;
    assign memtoRegE   = r_ctrl.mem_to_reg;
    assign aluSrcE     = r_ctrl.alu_src;
    assign branchE     = r_ctrl.branch;
    assign pcSrcE      = r_ctrl.pc_src;
    assign aluControlE = r_ctrl.alu_control;
    assign flagWriteE  = r_ctrl.flag_write;
    assign illegalE    = r_ctrl.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage with hand-computed expectations.
module tb_decode_stage;

    logic        clock = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] instD = '0;
    logic [31:0] pcPlus8D = '0;
    logic        enE = 1'b1;
    logic        flushE = 1'b0;
    logic        regWriteW = 1'b0;
    logic [3:0]  wa3W = '0;
    logic [31:0] wd3W = '0;
    logic [31:0] rd1E, rd2E, extImmE;
    logic [3:0]  wa3E, ra1E, ra2E, condE;
    logic        regWriteE, memWriteE, memtoRegE, aluSrcE, branchE, pcSrcE, illegalE;
    logic [1:0]  aluControlE, flagWriteE;

    int n_tests = 0;
    int n_fail = 0;

    decode_stage dut (
        .clock       (clock),
        .rst         (rst),
        .instD       (instD),
        .pcPlus8D    (pcPlus8D),
        .enE         (enE),
        .flushE      (flushE),
        .regWriteW   (regWriteW),
        .wa3W        (wa3W),
        .wd3W        (wd3W),
        .rd1E        (rd1E),
        .rd2E        (rd2E),
        .extImmE     (extImmE),
        .wa3E        (wa3E),
        .ra1E        (ra1E),
        .ra2E        (ra2E),
        .regWriteE   (regWriteE),
        .memWriteE   (memWriteE),
        .memtoRegE   (memtoRegE),
        .aluSrcE     (aluSrcE),
        .branchE     (branchE),
        .pcSrcE      (pcSrcE),
        .aluControlE (aluControlE),
        .flagWriteE  (flagWriteE),
        .condE       (condE),
        .illegalE    (illegalE)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wr_reg(input logic [3:0] a, input logic [31:0] d);
        regWriteW = 1'b1; wa3W = a; wd3W = d;
        tick();
        regWriteW = 1'b0;
    endtask

    function automatic logic [139:0] all_outs();
        return {rd1E, rd2E, extImmE, wa3E, ra1E, ra2E, regWriteE, memWriteE, memtoRegE,
                aluSrcE, branchE, pcSrcE, aluControlE, flagWriteE, condE, illegalE};
    endfunction

    task automatic test_reset();
        wr_reg(4'd9, 32'h0000_1234);
        rst = 1'b1;
        instD = 32'hE089_1009;  // ADD R1,R9,R9
        tick();
        tick();
        n_tests++;
        if (all_outs() !== '0) begin
            n_fail++; $display("FAIL reset_outs: got %h want 0", all_outs());
        end
        rst = 1'b0;
        tick();
        n_tests++;
        if (rd1E !== 32'd0) begin n_fail++; $display("FAIL reset_r9_clear: got %h want 0", rd1E); end
        n_tests++;
        if ({regWriteE, wa3E, ra1E, ra2E} !== {1'b1, 4'd1, 4'd9, 4'd9}) begin
            n_fail++; $display("FAIL reset_first_load: got %h want %h",
                {regWriteE, wa3E, ra1E, ra2E}, {1'b1, 4'd1, 4'd9, 4'd9});
        end
    endtask

    task automatic test_add_imm();
        wr_reg(4'd2, 32'd7);
        instD = 32'hE282_1005;  // ADD R1,R2,#5
        tick();
        n_tests++;
        if (rd1E !== 32'd7) begin n_fail++; $display("FAIL add_rd1: got %h want 7", rd1E); end
        n_tests++;
        if (extImmE !== 32'd5) begin n_fail++; $display("FAIL add_imm: got %h want 5", extImmE); end
        n_tests++;
        if ({aluSrcE, aluControlE, wa3E, regWriteE, flagWriteE, pcSrcE, condE, illegalE}
            !== {1'b1, 2'b00, 4'd1, 1'b1, 2'b00, 1'b0, 4'hE, 1'b0}) begin
            n_fail++; $display("FAIL add_ctrl: got %h want %h",
                {aluSrcE, aluControlE, wa3E, regWriteE, flagWriteE, pcSrcE, condE, illegalE},
                {1'b1, 2'b00, 4'd1, 1'b1, 2'b00, 1'b0, 4'hE, 1'b0});
        end
        instD = 32'h0282_1005;  // ADDEQ
        tick();
        n_tests++;
        if (condE !== 4'h0) begin n_fail++; $display("FAIL add_cond: got %h want 0", condE); end
    endtask

    task automatic test_write_through();
        instD = 32'hE183_4003;  // ORR R4,R3,R3
        regWriteW = 1'b1; wa3W = 4'd3; wd3W = 32'hDEAD_BEEF;
        tick();
        regWriteW = 1'b0;
        n_tests++;
        if ({rd1E, rd2E} !== {32'hDEAD_BEEF, 32'hDEAD_BEEF}) begin
            n_fail++; $display("FAIL wt_bypass: got %h %h want deadbeef", rd1E, rd2E);
        end
        n_tests++;
        if ({aluControlE, aluSrcE, wa3E, extImmE} !== {2'b11, 1'b0, 4'd4, 32'd3}) begin
            n_fail++; $display("FAIL wt_orr_ctrl: got %h want %h",
                {aluControlE, aluSrcE, wa3E, extImmE}, {2'b11, 1'b0, 4'd4, 32'd3});
        end
        tick();
        n_tests++;
        if (rd1E !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL wt_stored: got %h want deadbeef", rd1E);
        end
        wr_reg(4'd15, 32'h0BAD_0BAD);  // dropped
        pcPlus8D = 32'h0000_0200;
        instD = 32'hE28F_0000;  // ADD R0,R15,#0
        tick();
        n_tests++;
        if (rd1E !== 32'h0000_0200) begin
            n_fail++; $display("FAIL r15_read: got %h want 00000200", rd1E);
        end
    endtask

    task automatic test_branch();
        pcPlus8D = 32'h0000_0100;
        instD = 32'hEAFF_FFFE;  // B imm24=0xFFFFFE
        tick();
        n_tests++;
        if (rd1E !== 32'h0000_0100) begin n_fail++; $display("FAIL br_rd1: got %h want 100", rd1E); end
        n_tests++;
        if (extImmE !== 32'hFFFF_FFF8) begin
            n_fail++; $display("FAIL br_imm: got %h want fffffff8", extImmE);
        end
        n_tests++;
        if ({branchE, pcSrcE, regWriteE, aluSrcE, ra1E} !== {1'b1, 1'b1, 1'b0, 1'b1, 4'd15}) begin
            n_fail++; $display("FAIL br_ctrl: got %h want %h",
                {branchE, pcSrcE, regWriteE, aluSrcE, ra1E}, {1'b1, 1'b1, 1'b0, 1'b1, 4'd15});
        end
        instD = 32'hEB00_0004;  // BL +4 words
        tick();
        n_tests++;
        if ({regWriteE, wa3E, pcSrcE, extImmE} !== {1'b1, 4'd14, 1'b1, 32'd16}) begin
            n_fail++; $display("FAIL bl_ctrl: got %h want %h",
                {regWriteE, wa3E, pcSrcE, extImmE}, {1'b1, 4'd14, 1'b1, 32'd16});
        end
        instD = 32'hE281_F000;  // ADD R15,R1,#0
        tick();
        n_tests++;
        if ({pcSrcE, branchE, regWriteE} !== 3'b101) begin
            n_fail++; $display("FAIL pc_write: got %b want 101", {pcSrcE, branchE, regWriteE});
        end
    endtask

    task automatic test_mem();
        wr_reg(4'd5, 32'h0000_0055);
        instD = 32'hE586_500C;  // STR R5,[R6,#12]
        tick();
        n_tests++;
        if ({ra2E, rd2E} !== {4'd5, 32'h55}) begin
            n_fail++; $display("FAIL str_data: got %h want %h", {ra2E, rd2E}, {4'd5, 32'h55});
        end
        n_tests++;
        if ({memWriteE, regWriteE, memtoRegE, extImmE, ra1E, aluControlE, aluSrcE}
            !== {1'b1, 1'b0, 1'b0, 32'd12, 4'd6, 2'b00, 1'b1}) begin
            n_fail++; $display("FAIL str_ctrl: got %h want %h",
                {memWriteE, regWriteE, memtoRegE, extImmE, ra1E, aluControlE, aluSrcE},
                {1'b1, 1'b0, 1'b0, 32'd12, 4'd6, 2'b00, 1'b1});
        end
        instD = 32'hE516_7004;  // LDR R7,[R6,#-4]
        tick();
        n_tests++;
        if ({regWriteE, memtoRegE, memWriteE, aluControlE, wa3E, extImmE}
            !== {1'b1, 1'b1, 1'b0, 2'b01, 4'd7, 32'd4}) begin
            n_fail++; $display("FAIL ldr_ctrl: got %h want %h",
                {regWriteE, memtoRegE, memWriteE, aluControlE, wa3E, extImmE},
                {1'b1, 1'b1, 1'b0, 2'b01, 4'd7, 32'd4});
        end
    endtask

    task automatic test_illegal_flags();
        instD = 32'hEC00_0000;  // op=11
        tick();
        n_tests++;
        if ({illegalE, regWriteE, memWriteE, memtoRegE, branchE, pcSrcE, flagWriteE}
            !== 8'b1000_0000) begin
            n_fail++; $display("FAIL ill_op11: got %b want 10000000",
                {illegalE, regWriteE, memWriteE, memtoRegE, branchE, pcSrcE, flagWriteE});
        end
        instD = 32'hE031_1000;  // EORS: unsupported cmd
        tick();
        n_tests++;
        if ({illegalE, regWriteE, flagWriteE} !== 4'b1000) begin
            n_fail++; $display("FAIL ill_cmd: got %b want 1000", {illegalE, regWriteE, flagWriteE});
        end
        instD = 32'hE351_0005;  // CMP R1,#5
        tick();
        n_tests++;
        if ({regWriteE, flagWriteE, aluControlE, illegalE} !== 6'b0_11_01_0) begin
            n_fail++; $display("FAIL cmp_ctrl: got %b want 011010",
                {regWriteE, flagWriteE, aluControlE, illegalE});
        end
        instD = 32'hE211_0001;  // ANDS R0,R1,#1
        tick();
        n_tests++;
        if ({flagWriteE, aluControlE, regWriteE} !== 5'b10_10_1) begin
            n_fail++; $display("FAIL ands_ctrl: got %b want 10101",
                {flagWriteE, aluControlE, regWriteE});
        end
        instD = 32'hE291_0001;  // ADDS R0,R1,#1
        tick();
        n_tests++;
        if (flagWriteE !== 2'b11) begin
            n_fail++; $display("FAIL adds_flags: got %b want 11", flagWriteE);
        end
    endtask

    task automatic test_stall_flush();
        logic [139:0] held;
        instD = 32'hE282_1005;  // ADD R1,R2,#5 with R2=7
        tick();
        held = all_outs();
        n_tests++;
        if ({rd1E, extImmE} !== {32'd7, 32'd5}) begin
            n_fail++; $display("FAIL stall_setup: got %h want %h", {rd1E, extImmE}, {32'd7, 32'd5});
        end
        enE = 1'b0;
        for (int i = 0; i < 3; i++) begin
            instD = (i == 0) ? 32'hEAFF_FFFE : ((i == 1) ? 32'hE351_0005 : 32'hEC00_0000);
            regWriteW = (i == 0); wa3W = 4'd8; wd3W = 32'h0000_CAFE;
            tick();
            n_tests++;
            if ({rd1E, extImmE, wa3E, regWriteE, aluSrcE, branchE, illegalE}
                !== {32'd7, 32'd5, 4'd1, 1'b1, 1'b1, 1'b0, 1'b0}) begin
                n_fail++; $display("FAIL stall_hold%0d: got %h want %h", i,
                    {rd1E, extImmE, wa3E, regWriteE, aluSrcE, branchE, illegalE},
                    {32'd7, 32'd5, 4'd1, 1'b1, 1'b1, 1'b0, 1'b0});
            end
        end
        regWriteW = 1'b0;
        n_tests++;
        if (all_outs() !== held) begin
            n_fail++; $display("FAIL stall_all: got %h want %h", all_outs(), held);
        end
        flushE = 1'b1;
        tick();
        n_tests++;
        if (all_outs() !== '0) begin
            n_fail++; $display("FAIL flush_stall: got %h want 0", all_outs());
        end
        flushE = 1'b0;
        enE = 1'b1;
        instD = 32'hE288_0000;  // ADD R0,R8,#0: R8 written during stall
        tick();
        n_tests++;
        if (rd1E !== 32'h0000_CAFE) begin
            n_fail++; $display("FAIL stall_write: got %h want 0000cafe", rd1E);
        end
    endtask

    initial begin
        test_reset();
        test_add_imm();
        test_write_through();
        test_branch();
        test_mem();
        test_illegal_flags();
        test_stall_flush();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
